// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit and the decoder that drives it.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication/legality on the request side,
// byte/half selection and sign/zero extension on the load-return side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  output logic        o_legal,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_legal = 1'b0;
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    if (i_is_store) begin
      case (i_func3)
        F3_B: begin
          o_legal = 1'b1;
          o_be    = 4'b0001 << i_off;
          o_wdata = {4{i_store_data[7:0]}};
        end
        F3_H: begin
          o_legal = ~i_off[0];
          o_be    = 4'b0011 << {i_off[1], 1'b0};
          o_wdata = {2{i_store_data[15:0]}};
        end
        F3_W:    o_legal = (i_off == 2'b00);
        default: o_legal = 1'b0;
      endcase
    end else begin
      // Reads always fetch the whole word; lane selection happens on return.
      case (i_func3)
        F3_B, F3_BU: o_legal = 1'b1;
        F3_H, F3_HU: o_legal = ~i_off[0];
        F3_W:        o_legal = (i_off == 2'b00);
        default:     o_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_ld_func3)
      F3_B:    o_load_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_ext = {24'd0, w_byte};
      F3_H:    o_load_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_ext = {16'd0, w_half};
      F3_W:    o_load_ext = i_rdata;
      default: o_load_ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: IDLE -> BUSY (req/ack with timeout) -> DONE,
// stalling the core until the access retires.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_func3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_done,
  output logic              o_stall,
  output logic              o_err_access,
  output logic              o_err_bus,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic [DATA_W-1:0] i_bus_rdata,
  input  logic              i_bus_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t r_state, w_state_next;

  logic              r_bus_req, r_bus_we, r_done, r_err_access, r_err_bus;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [DATA_W-1:0] r_bus_wdata, r_load_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic              r_is_load;

  logic              w_legal, w_start, w_acc_err, w_ack, w_timeout;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_load_ext;

  lsu_align u_align (
    .i_is_store   (i_mem_write),
    .i_func3      (i_func3),
    .i_off        (i_addr[1:0]),
    .i_store_data (i_store_data),
    .o_legal      (w_legal),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .i_ld_func3   (r_func3),
    .i_ld_off     (r_off),
    .i_rdata      (i_bus_rdata),
    .o_load_ext   (w_load_ext)
  );

  // Both read and write high is illegal even if the func3/alignment would pass.
  always_comb begin
    w_start      = 1'b0;
    w_acc_err    = 1'b0;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    w_state_next = r_state;
    o_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        w_start   = (i_mem_read ^ i_mem_write) & w_legal;
        w_acc_err = (i_mem_read | i_mem_write) & ~w_start;
        o_stall   = w_start;
        if (w_start) w_state_next = BUSY;
      end
      BUSY: begin
        o_stall   = 1'b1;
        w_ack     = i_bus_ack;
        w_timeout = ~i_bus_ack & (r_cnt == CNT_LAST);
        if (w_ack || w_timeout) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_be     <= 4'b0000;
      r_bus_wdata  <= '0;
      r_done       <= 1'b0;
      r_err_access <= 1'b0;
      r_err_bus    <= 1'b0;
      r_load_data  <= '0;
      r_cnt        <= '0;
      r_func3      <= 3'b000;
      r_off        <= 2'b00;
      r_is_load    <= 1'b0;
    end else begin
      r_bus_req    <= (w_state_next == BUSY);
      r_done       <= (r_state == BUSY) && (w_state_next == DONE);
      r_err_access <= w_acc_err;
      r_err_bus    <= w_timeout;
      if (w_start) begin
        r_bus_we    <= i_mem_write;
        r_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= i_mem_write ? w_wdata : '0;
        r_func3     <= i_func3;
        r_off       <= i_addr[1:0];
        r_is_load   <= i_mem_read;
        r_cnt       <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack) r_load_data <= r_is_load ? w_load_ext : '0;
      else if (w_timeout) r_load_data <= '0;
    end
  end

  assign o_bus_req    = r_bus_req;
  assign o_bus_we     = r_bus_we;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_be     = r_bus_be;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_done       = r_done;
  assign o_err_access = r_err_access;
  assign o_err_bus    = r_err_bus;
  assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: stimulus pushes expected
// completions, a negedge monitor pops and compares on done/err_access.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = '0, store_data = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic        done, stall, err_access, err_bus, bus_req, bus_we;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  typedef struct {
    logic        is_acc;
    logic [31:0] load;
    logic        err_bus;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_func3(func3),
    .i_addr(addr), .i_store_data(store_data),
    .o_load_data(load_data), .o_done(done), .o_stall(stall),
    .o_err_access(err_access), .o_err_bus(err_bus),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req && !prev_req) req_rises++;
      prev_req = bus_req;
      if (done || err_access) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: done=%0b err_access=%0b with empty scoreboard", done, err_access);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_err_access", {31'd0, err_access}, {31'd0, e.is_acc});
          check("sb_done", {31'd0, done}, {31'd0, ~e.is_acc});
          if (!e.is_acc) begin
            check("sb_load_data", load_data, e.load);
            check("sb_err_bus", {31'd0, err_bus}, {31'd0, e.err_bus});
            $display("txn done: load_data=0x%08h err_bus=%0b", load_data, err_bus);
          end else begin
            $display("txn err_access: bus_req=%0b", bus_req);
          end
        end
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  // Legal access; ack_at = BUSY cycle index carrying ack (-1 = never).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int ack_at,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                        input logic exp_eb, input int exp_lat);
    int  n;
    logic stall_ok, got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
    #1;
    check("stall_idle", {31'd0, stall}, 32'd1);
    sb_q.push_back('{1'b0, exp_load, exp_eb});
    @(negedge clk);
    check("bus_req", {31'd0, bus_req}, 32'd1);
    check("bus_we", {31'd0, bus_we}, {31'd0, wr});
    check("bus_addr", bus_addr, exp_addr);
    check("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
    if (wr) check("bus_wdata", bus_wdata, exp_wdata);
    n = 0; stall_ok = 1'b1; got = 1'b0;
    while (n < 40) begin
      if (!stall || !bus_req) stall_ok = 1'b0;
      if (n == ack_at) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
      n++;
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("busy_stall_req", {31'd0, stall_ok}, 32'd1);
    check("latency", n, exp_lat);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("req_done", {31'd0, bus_req}, 32'd0);
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = 32'hFFFF_FFFF;
    #1;
    check("stall_illegal", {31'd0, stall}, 32'd0);
    sb_q.push_back('{1'b1, 32'd0, 1'b0});
    @(negedge clk);
    check("req_illegal", {31'd0, bus_req}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic quiet;
    repeat (2) @(negedge clk);
    check("rst_load_data", load_data, 32'd0);
    check("rst_flags", {26'd0, done, stall, err_access, err_bus, bus_req, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;

    //      rd   wr   f3     addr          sd            rdata         ack  exp_addr      be       wdata         load          eb   lat
    access(1'b1,1'b0,F3_B, 32'h0000_0103,32'h0,        32'h80AA_BBCC, 2, 32'h0000_0100,4'b1111,32'h0,        32'hFFFF_FF80,1'b0, 3);
    access(1'b0,1'b1,F3_H, 32'h0000_0202,32'h1234_ABCD,32'h0,         0, 32'h0000_0200,4'b1100,32'hABCD_ABCD,32'h0,        1'b0, 1);
    illegal(1'b1,1'b0,F3_W, 32'h0000_0101);
    access(1'b1,1'b0,F3_HU,32'h0000_0000,32'h0,        32'hFFFF_FFFF,-1, 32'h0000_0000,4'b1111,32'h0,        32'h0,        1'b1,16);
    access(1'b1,1'b0,F3_BU,32'h0000_0101,32'h0,        32'h1234_F6AB, 1, 32'h0000_0100,4'b1111,32'h0,        32'h0000_00F6,1'b0, 2);
    access(1'b1,1'b0,F3_H, 32'h0000_0102,32'h0,        32'h8001_7FFF, 0, 32'h0000_0100,4'b1111,32'h0,        32'hFFFF_8001,1'b0, 1);
    access(1'b1,1'b0,F3_W, 32'h0000_0104,32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0104,4'b1111,32'h0,        32'hDEAD_BEEF,1'b0, 1);
    access(1'b1,1'b0,F3_W, 32'h0000_0108,32'h0,        32'h0123_4567, 3, 32'h0000_0108,4'b1111,32'h0,        32'h0123_4567,1'b0, 4);
    access(1'b0,1'b1,F3_B, 32'h0000_00F3,32'h0000_00A5,32'h0,         1, 32'h0000_00F0,4'b1000,32'hA5A5_A5A5,32'h0,        1'b0, 2);
    access(1'b0,1'b1,F3_W, 32'h0000_0010,32'hCAFE_F00D,32'hFFFF_FFFF, 0, 32'h0000_0010,4'b1111,32'hCAFE_F00D,32'h0,        1'b0, 1);
    access(1'b1,1'b0,F3_W, 32'h0000_0020,32'h0,        32'h55AA_55AA,15, 32'h0000_0020,4'b1111,32'h0,        32'h55AA_55AA,1'b0,16);
    illegal(1'b1,1'b0,3'b011,32'h0000_0000);
    illegal(1'b0,1'b1,3'b100,32'h0000_0000);
    illegal(1'b1,1'b1,F3_W, 32'h0000_0000);
    illegal(1'b0,1'b1,F3_H, 32'h0000_0201);

    // Reset in the middle of a transaction, then a stray ack.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; func3 = F3_W; addr = 32'h0000_0040;
    repeat (2) @(negedge clk);
    check("req_before_rst", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    check("req_async_drop", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || bus_req || load_data != 32'd0) quiet = 1'b0;
    end
    check("late_ack_ignored", {31'd0, quiet}, 32'd1);

    repeat (2) @(negedge clk);
    check("one_req_per_access", req_rises, 32'd11);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

endmodule
